// File: rtl/grant_stream_ctrl_if.sv
// rtl/grant_stream_ctrl_if.sv - selector, channel and shared-output signals of grant_stream_ctrl
interface grant_stream_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DATA_W = 8
);
  logic [WIDTH-1:0]        req;
  logic [WIDTH*DATA_W-1:0] ch_data;
  logic [WIDTH-1:0]        ch_valid;
  logic [WIDTH-1:0]        ch_last;
  logic [WIDTH-1:0]        ch_ready;
  logic                    sel_enable;
  logic                    sel_latch;
  logic [WIDTH-1:0]        grants;
  logic                    granted;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;

  // controller view
  modport slave (
    input  req, ch_data, ch_valid, ch_last, grants, granted, out_ready,
    output ch_ready, sel_enable, sel_latch, out_data, out_valid, out_last
  );

  // environment view: channel sources, selector and transmit path
  modport master (
    output req, ch_data, ch_valid, ch_last, grants, granted, out_ready,
    input  ch_ready, sel_enable, sel_latch, out_data, out_valid, out_last
  );
endinterface

// File: rtl/grant_stream_ctrl.sv
// rtl/grant_stream_ctrl.sv - one-packet-per-grant sequencer and data mux behind a priority selector
module grant_stream_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DATA_W   = 8,
  parameter int IDLE_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  grant_stream_ctrl_if.slave bus,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               abort_o
);

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, XFER, RELEASE} state_t;

  // counter value that, with one more empty cycle, reaches IDLE_MAX
  localparam logic [15:0] IDLE_LIM = 16'(IDLE_MAX - 1);

  state_t            state_q;
  logic [15:0]       idle_cnt_q;
  logic              in_xfer;
  logic              beat_acc;
  logic              last_acc;
  logic [DATA_W-1:0] mux_data;
  logic              mux_last;

  // AND-OR mux of the granted channel; grants are trusted to be one-hot
  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      mux_data = mux_data | (bus.ch_data[i*DATA_W +: DATA_W] & {DATA_W{bus.grants[i]}});
      mux_last = mux_last | (bus.ch_last[i] & bus.grants[i]);
    end
  end

  // stream path is live only in XFER; selector controls and status pulses decode from state
  always_comb begin
    in_xfer        = (state_q == XFER);
    bus.out_valid  = in_xfer & |(bus.ch_valid & bus.grants);
    bus.out_data   = in_xfer ? mux_data : '0;
    bus.out_last   = in_xfer & mux_last;
    bus.ch_ready   = in_xfer ? (bus.grants & {WIDTH{bus.out_ready}}) : '0;
    beat_acc       = bus.out_valid & bus.out_ready;
    last_acc       = beat_acc & bus.out_last;
    // a last beat accepted in the same cycle the grant drops still completes the packet
    abort_o        = in_xfer & ~bus.granted & ~last_acc;
    timeout_o      = in_xfer & ~beat_acc & ~abort_o & (idle_cnt_q == IDLE_LIM);
    bus.sel_enable = (state_q == IDLE);
    // RELEASE latches with enable low so the selector clears its grants
    bus.sel_latch  = ((state_q == IDLE) & |bus.req) | (state_q == RELEASE);
    busy_o         = (state_q != IDLE);
  end

  // packet sequencing and the XFER inactivity counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          if (|bus.req) state_q <= GRANT_WAIT;
        end
        GRANT_WAIT: begin
          state_q <= bus.granted ? XFER : RELEASE;
        end
        XFER: begin
          idle_cnt_q <= beat_acc ? 16'd0 : idle_cnt_q + 16'd1;
          if (last_acc || abort_o || timeout_o) state_q <= RELEASE;
        end
        default: begin
          idle_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule
